// File: rtl/process_element_pkg.sv
// process_element_pkg
// Shared definitions for the processing-element MAC datapath.
//   W_W / X_W / P_W      : weight, activation and product widths of the multiplier
//   DEF_ACC_W / DEF_OUT_W / DEF_SHIFT : default accumulator, result and shift settings
//   requant()            : round-half-up, arithmetic shift and saturating clip of a sum
package process_element_pkg;

    localparam int W_W = 9;
    localparam int X_W = 16;
    localparam int P_W = 25;

    localparam int DEF_ACC_W = 32;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 8;

    // requant works on a wide signed value so that the rounding add cannot
    // wrap for any accumulator width the MAC supports.
    localparam int RQ_W = 64;

    typedef struct packed {
        logic                   sat;
        logic signed [RQ_W-1:0] data;
    } requant_t;

    // Adds half an LSB of the shifted result (when shift > 0), shifts right
    // arithmetically, then clips to the signed range of out_w bits.
    function automatic requant_t requant(
        input logic signed [RQ_W-1:0] sum,
        input int                     shift,
        input int                     out_w
    );
        logic signed [RQ_W-1:0] one;
        logic signed [RQ_W-1:0] rounded;
        logic signed [RQ_W-1:0] shifted;
        logic signed [RQ_W-1:0] max_v;
        logic signed [RQ_W-1:0] min_v;
        requant_t               r;
        one     = 1;
        rounded = sum;
        if (shift > 0) begin
            rounded = sum + (one <<< (shift - 1));
        end
        shifted = rounded >>> shift;
        max_v   = (one <<< (out_w - 1)) - one;
        min_v   = ~max_v;
        r.sat   = 1'b0;
        r.data  = shifted;
        if (shifted > max_v) begin
            r.sat  = 1'b1;
            r.data = max_v;
        end else if (shifted < min_v) begin
            r.sat  = 1'b1;
            r.data = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/process_element_mul_mul_9s_16s_25_4_1.sv
// process_element_mul_mul_9s_16s_25_4_1
// Signed pipelined multiplier, all stages gated by a common clock enable.
// The data registers carry no reset; callers track validity separately.
//   clk  : clock
//   ce   : clock enable for every pipeline stage
//   din0 : signed multiplicand (din0_WIDTH)
//   din1 : signed multiplier (din1_WIDTH)
//   dout : signed product (dout_WIDTH), NUM_STAGE-1 enabled edges after din0/din1
module process_element_mul_mul_9s_16s_25_4_1 #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 4,
    parameter int din0_WIDTH = 9,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    // One operand register stage followed by PIPE_DEPTH product stages.
    localparam int PIPE_DEPTH = NUM_STAGE - 2;

    if (NUM_STAGE < 2 || ID < 0) begin : g_bad_param
        $error("process_element_mul: NUM_STAGE must be >= 2 and ID >= 0");
    end

    logic signed [din0_WIDTH-1:0] a_q, a_d;
    logic signed [din1_WIDTH-1:0] b_q, b_d;
    logic signed [dout_WIDTH-1:0] prod;
    logic signed [dout_WIDTH-1:0] pipe_q [PIPE_DEPTH];
    logic signed [dout_WIDTH-1:0] pipe_d [PIPE_DEPTH];

    // Operands are widened to the product width before multiplying so the
    // full signed product is formed, not a truncated self-sized one.
    always_comb begin
        prod = dout_WIDTH'(a_q) * dout_WIDTH'(b_q);
        a_d  = a_q;
        b_d  = b_q;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (ce) begin
            a_d       = din0;
            b_d       = din1;
            pipe_d[0] = prod;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        pipe_q <= pipe_d;
    end

    assign dout = pipe_q[PIPE_DEPTH-1];

endmodule

// File: rtl/process_element_mac_ctrl.sv
// process_element_mac_ctrl
// Feeds (weight, activation, last) tuples into the pipelined multiplier,
// tracks each product with a shadow valid/last pipeline, accumulates each
// vector and emits one requantised result per vector.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand stream handshake
//   in_w, in_x, in_last : signed weight, signed activation, end-of-vector
//   out_valid/out_ready : result stream handshake
//   out_data, out_sat   : signed result and saturation flag
module process_element_mac_ctrl
    import process_element_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int SHIFT       = DEF_SHIFT,
    parameter int OUT_W       = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_W-1:0]   in_w,
    input  logic signed [X_W-1:0]   in_x,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    logic                    adv;
    logic                    accept;
    logic                    tail_vld;
    logic                    tail_last;
    logic signed [P_W-1:0]   mul_dout;

    logic [MUL_LATENCY-1:0]  vld_sr_q, vld_sr_d;
    logic [MUL_LATENCY-1:0]  last_sr_q, last_sr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    first_q, first_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] sum;
    requant_t                rq;
    logic                    rq_unused;

    process_element_mul_mul_9s_16s_25_4_1 #(
        .ID         (1),
        .NUM_STAGE  (MUL_LATENCY + 1),
        .din0_WIDTH (W_W),
        .din1_WIDTH (X_W),
        .dout_WIDTH (P_W)
    ) u_mul (
        .clk  (clk),
        .ce   (adv),
        .din0 (in_w),
        .din1 (in_x),
        .dout (mul_dout)
    );

    // A result held back by the consumer freezes the entire pipeline,
    // including the multiplier, so no in-flight product is lost.
    always_comb begin
        adv       = !(out_valid_q && !out_ready);
        accept    = in_valid && adv;
        tail_vld  = vld_sr_q[MUL_LATENCY-1];
        tail_last = last_sr_q[MUL_LATENCY-1];

        acc_base  = first_q ? '0 : acc_q;
        sum       = acc_base + ACC_W'(mul_dout);
        rq        = requant(RQ_W'(sum), SHIFT, OUT_W);

        vld_sr_d    = vld_sr_q;
        last_sr_d   = last_sr_q;
        acc_d       = acc_q;
        first_d     = first_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (adv) begin
            vld_sr_d  = (vld_sr_q << 1) | MUL_LATENCY'(accept);
            last_sr_d = (last_sr_q << 1) | MUL_LATENCY'(accept && in_last);
            if (tail_vld) begin
                if (tail_last) begin
                    first_d     = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = rq.data[OUT_W-1:0];
                    out_sat_d   = rq.sat;
                end else begin
                    acc_d   = sum;
                    first_d = 1'b0;
                end
            end
        end
    end

    // After clipping, the bits above OUT_W are pure sign extension.
    assign rq_unused = ^rq.data[RQ_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr_q    <= '0;
            last_sr_q   <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_process_element_mac_ctrl.sv
// tb_process_element_mac_ctrl
// Three MAC instances (SHIFT = 0, 8, 1) share one operand and result stream;
// each scenario checks the instance whose shift setting it targets.
module tb_process_element_mac_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_last;
    logic               out_ready;
    logic signed [8:0]  in_w;
    logic signed [15:0] in_x;

    logic               in_ready_0, in_ready_8, in_ready_1;
    logic               out_valid_0, out_valid_8, out_valid_1;
    logic signed [15:0] out_data_0, out_data_8, out_data_1;
    logic               out_sat_0, out_sat_8, out_sat_1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic signed [15:0] q_s0 [$];
    logic signed [15:0] q_s8 [$];
    logic signed [15:0] q_s1 [$];
    logic               q_sat [$];
    int                 q_cyc [$];

    always #5 clk = ~clk;

    process_element_mac_ctrl #(.SHIFT(0)) dut_s0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_0),
        .in_w(in_w), .in_x(in_x), .in_last(in_last), .out_valid(out_valid_0),
        .out_ready(out_ready), .out_data(out_data_0), .out_sat(out_sat_0)
    );

    process_element_mac_ctrl #(.SHIFT(8)) dut_s8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_8),
        .in_w(in_w), .in_x(in_x), .in_last(in_last), .out_valid(out_valid_8),
        .out_ready(out_ready), .out_data(out_data_8), .out_sat(out_sat_8)
    );

    process_element_mac_ctrl #(.SHIFT(1)) dut_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_1),
        .in_w(in_w), .in_x(in_x), .in_last(in_last), .out_valid(out_valid_1),
        .out_ready(out_ready), .out_data(out_data_1), .out_sat(out_sat_1)
    );

    // Free-running edge counter used to time result handshakes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Record every result that will be taken at the coming rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid_0 && out_ready) begin
            q_s0.push_back(out_data_0);
            q_s8.push_back(out_data_8);
            q_s1.push_back(out_data_1);
            q_sat.push_back(out_sat_0);
            q_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clear_results();
        q_s0.delete();
        q_s8.delete();
        q_s1.delete();
        q_sat.delete();
        q_cyc.delete();
    endtask

    // Presents one tuple and returns just after the edge that accepts it.
    task automatic send_tuple(input int w, input int x, input logic last);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_w     = 9'(w);
        in_x     = 16'(x);
        in_last  = last;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready_0) begin
                done = 1'b1;
            end
            step();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: tuple (%0d,%0d) not accepted, in_ready=%b required 1", w, x, in_ready_0);
        end
    endtask

    // Waits for n results, then lingers to expose any duplicates.
    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (q_s0.size() < n && k < 200) begin
            step();
            k++;
        end
        if (q_s0.size() < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: got %0d results, required %0d", q_s0.size(), n);
        end
        repeat (10) step();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        checks++;
        if (out_valid_0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid_0);
        end
        checks++;
        if (out_data_0 !== 16'sd0) begin
            errors++;
            $display("[TB] FAIL reset_out_data: got %0d required 0", out_data_0);
        end
        checks++;
        if (out_sat_0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_sat: got %b required 0", out_sat_0);
        end
        checks++;
        if (in_ready_0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready_0);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_accumulate();
        int lat;
        $display("[TB] test_accumulate");
        clear_results();
        send_tuple(1, 100, 1'b0);
        send_tuple(2, 100, 1'b0);
        send_tuple(3, 100, 1'b0);
        send_tuple(4, 100, 1'b1);
        idle();
        lat = 0;
        while (!out_valid_0 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL acc_latency: out_valid after %0d further edges, required 3", lat);
        end
        wait_results(1);
        checks++;
        if (q_s0.size() !== 1) begin
            errors++;
            $display("[TB] FAIL acc_count: got %0d results required 1", q_s0.size());
        end
        checks++;
        if (q_s0[0] !== 16'sd1000) begin
            errors++;
            $display("[TB] FAIL acc_data_s0: got %0d required 1000", q_s0[0]);
        end
        checks++;
        if (q_sat[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL acc_sat_s0: got %b required 0", q_sat[0]);
        end
        checks++;
        if (q_s8[0] !== 16'sd4) begin
            errors++;
            $display("[TB] FAIL acc_data_s8: got %0d required 4", q_s8[0]);
        end
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        clear_results();
        send_tuple(-256, 32767, 1'b1);
        send_tuple(255, -32768, 1'b1);
        idle();
        wait_results(2);
        checks++;
        if (q_s8.size() !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d results required 2", q_s8.size());
        end
        checks++;
        if (q_s8[0] !== -16'sd32767) begin
            errors++;
            $display("[TB] FAIL b2b_first: got %0d required -32767", q_s8[0]);
        end
        checks++;
        if (q_s8[1] !== -16'sd32640) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %0d required -32640", q_s8[1]);
        end
        checks++;
        if (q_cyc[1] - q_cyc[0] !== 1) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles required 1", q_cyc[1] - q_cyc[0]);
        end
        checks++;
        if (q_s0[0] !== -16'sd32768 || q_sat[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_s0_clip: got %0d sat %b required -32768 sat 1", q_s0[0], q_sat[0]);
        end
    endtask

    task automatic test_saturation();
        $display("[TB] test_saturation");
        clear_results();
        send_tuple(255, 32767, 1'b0);
        send_tuple(255, 32767, 1'b1);
        send_tuple(-256, 32767, 1'b0);
        send_tuple(-256, 32767, 1'b1);
        idle();
        wait_results(2);
        checks++;
        if (q_s0[0] !== 16'sd32767 || q_sat[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_pos: got %0d sat %b required 32767 sat 1", q_s0[0], q_sat[0]);
        end
        checks++;
        if (q_s0[1] !== -16'sd32768 || q_sat[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_neg: got %0d sat %b required -32768 sat 1", q_s0[1], q_sat[1]);
        end
    endtask

    task automatic test_stall();
        int k;
        $display("[TB] test_stall");
        clear_results();
        out_ready = 1'b0;
        send_tuple(1, 1, 1'b0);
        send_tuple(2, 2, 1'b1);
        send_tuple(1, 10, 1'b0);
        send_tuple(2, 10, 1'b0);
        idle();
        k = 0;
        while (!out_valid_0 && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (out_valid_0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_pending: out_valid %b required 1", out_valid_0);
        end
        in_valid = 1'b1;
        in_w     = 9'sd3;
        in_x     = 16'sd10;
        in_last  = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready_0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_in_ready cycle %0d: got %b required 0", c, in_ready_0);
            end
            checks++;
            if (out_valid_0 !== 1'b1 || out_data_0 !== 16'sd5) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle %0d: valid %b data %0d required valid 1 data 5", c, out_valid_0, out_data_0);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready_0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: in_ready %b required 1", in_ready_0);
        end
        send_tuple(3, 10, 1'b1);
        idle();
        wait_results(2);
        checks++;
        if (q_s0.size() !== 2) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d results required 2", q_s0.size());
        end
        checks++;
        if (q_s0[0] !== 16'sd5) begin
            errors++;
            $display("[TB] FAIL stall_first: got %0d required 5", q_s0[0]);
        end
        checks++;
        if (q_s0[1] !== 16'sd60) begin
            errors++;
            $display("[TB] FAIL stall_second: got %0d required 60", q_s0[1]);
        end
    endtask

    task automatic test_rounding();
        $display("[TB] test_rounding");
        clear_results();
        send_tuple(1, 3, 1'b1);
        send_tuple(-1, 3, 1'b1);
        idle();
        wait_results(2);
        checks++;
        if (q_s1[0] !== 16'sd2) begin
            errors++;
            $display("[TB] FAIL round_pos: got %0d required 2", q_s1[0]);
        end
        checks++;
        if (q_s1[1] !== -16'sd1) begin
            errors++;
            $display("[TB] FAIL round_neg: got %0d required -1", q_s1[1]);
        end
    endtask

    task automatic test_reset_mid_vector();
        $display("[TB] test_reset_mid_vector");
        clear_results();
        send_tuple(1, 1, 1'b0);
        send_tuple(2, 2, 1'b0);
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_results();
        send_tuple(5, 10, 1'b1);
        idle();
        wait_results(1);
        checks++;
        if (q_s0.size() !== 1) begin
            errors++;
            $display("[TB] FAIL rst_mid_count: got %0d results required 1", q_s0.size());
        end
        checks++;
        if (q_s0[0] !== 16'sd50) begin
            errors++;
            $display("[TB] FAIL rst_mid_data: got %0d required 50", q_s0[0]);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_w      = '0;
        in_x      = '0;
        out_ready = 1'b1;
        repeat (3) step();
        test_reset();
        test_accumulate();
        test_back_to_back();
        test_saturation();
        test_stall();
        test_rounding();
        test_reset_mid_vector();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
